tree_traversal_unit: RTL and testbench



---
 rtl/sadd_pkg.sv | 28 ++
 rtl/node_comparator.sv | 21 ++
 rtl/tree_traversal_unit.sv | 163 ++++++++++++++++
 tb/tb_tree_traversal_unit.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sadd_pkg.sv
// sadd_pkg: shared defaults, FSM encoding and size derivations for the tree traversal unit.
// Revision 1.0
`default_nettype none

package sadd_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 3;
  localparam int DEF_N_FEAT = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int nodes_of(input int depth);
    return (1 << depth) - 1;
  endfunction

  // Selector width never collapses to zero, even for a single feature.
  function automatic int fidx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/node_comparator.sv
// node_comparator: signed feature-versus-threshold decision; node index rides alongside.
// Revision 1.0
`default_nettype none

module node_comparator #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 4
) (
  input  logic signed [DATA_W-1:0] feature_i,
  input  logic signed [DATA_W-1:0] weight_i,
  input  logic        [IDX_W-1:0]  node_i,
  output logic                     decision_o,
  output logic        [IDX_W-1:0]  node_o
);

  assign decision_o = (feature_i <= weight_i);
  assign node_o     = node_i;

endmodule

`default_nettype wire

// File: rtl/tree_traversal_unit.sv
// tree_traversal_unit: walks a configurable binary decision tree one level per cycle.
// Revision 1.0
`default_nettype none

module tree_traversal_unit
  import sadd_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int N_FEAT = DEF_N_FEAT,
  localparam int NODES  = nodes_of(DEPTH),
  localparam int FIDX_W = fidx_width(N_FEAT)
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       io_cfg_we,
  input  logic [DEPTH-1:0]           io_cfg_addr,
  input  logic signed [DATA_W-1:0]   io_cfg_weight,
  input  logic [FIDX_W-1:0]          io_cfg_fidx,
  input  logic                       io_req_valid,
  output logic                       io_req_ready,
  input  logic [N_FEAT*DATA_W-1:0]   io_req_bits_features,
  output logic                       io_resp_valid,
  input  logic                       io_resp_ready,
  output logic [DEPTH-1:0]           io_resp_bits_leaf,
  output logic [DEPTH-1:0]           io_resp_bits_path,
  output logic                       io_resp_bits_err,
  output logic                       io_busy
);

  // Node index reaches 2^(DEPTH+1)-2 on the final step, hence one extra bit.
  localparam int NODE_W = DEPTH + 1;
  localparam int LVL_W  = fidx_width(DEPTH);

  state_e state_q, state_d;

  logic [NODE_W-1:0] node_q, node_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [DEPTH-1:0]  path_q, path_d;
  logic [DEPTH-1:0]  leaf_q, leaf_d;
  logic              err_q, err_d;

  logic signed [DATA_W-1:0] feat_q   [N_FEAT];
  logic signed [DATA_W-1:0] weight_q [NODES];
  logic [FIDX_W-1:0]        fidx_q   [NODES];

  logic                     w_accept;
  logic                     w_cfg_wr;
  logic [DEPTH-1:0]         w_node_idx;
  logic [FIDX_W-1:0]        w_fidx;
  logic                     w_fidx_ok;
  logic signed [DATA_W-1:0] w_feat;
  logic                     w_cmp_dec;
  logic [NODE_W-1:0]        w_cmp_node;
  logic                     w_decision;
  logic [NODE_W-1:0]        w_child;
  logic                     w_last;

  assign w_accept   = io_req_valid && (state_q == ST_IDLE);
  assign w_cfg_wr   = io_cfg_we && (state_q == ST_IDLE) && (int'(io_cfg_addr) < NODES);
  assign w_node_idx = node_q[DEPTH-1:0];
  assign w_fidx     = fidx_q[w_node_idx];
  assign w_fidx_ok  = (int'(w_fidx) < N_FEAT);
  assign w_last     = (level_q == LVL_W'(DEPTH - 1));

  always_comb begin
    w_feat = '0;
    for (int k = 0; k < N_FEAT; k++) begin
      if (w_fidx == FIDX_W'(k)) w_feat = feat_q[k];
    end
  end

  node_comparator #(
    .DATA_W (DATA_W),
    .IDX_W  (NODE_W)
  ) u_cmp (
    .feature_i  (w_feat),
    .weight_i   (weight_q[w_node_idx]),
    .node_i     (node_q),
    .decision_o (w_cmp_dec),
    .node_o     (w_cmp_node)
  );

  // An invalid selector forces the right branch regardless of the compare.
  assign w_decision = w_cmp_dec && w_fidx_ok;
  assign w_child    = (w_cmp_node << 1) + (w_decision ? NODE_W'(1) : NODE_W'(2));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (w_accept)      state_d = ST_EVAL;
      ST_EVAL: if (w_last)        state_d = ST_DONE;
      ST_DONE: if (io_resp_ready) state_d = ST_IDLE;
      default:                    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    io_req_ready  = (state_q == ST_IDLE);
    io_resp_valid = (state_q == ST_DONE);
    io_busy       = (state_q != ST_IDLE);
  end

  always_comb begin
    node_d  = node_q;
    level_d = level_q;
    path_d  = path_q;
    leaf_d  = leaf_q;
    err_d   = err_q;
    if (w_accept) begin
      node_d  = '0;
      level_d = '0;
      path_d  = '0;
      err_d   = 1'b0;
    end else if (state_q == ST_EVAL) begin
      node_d          = w_child;
      level_d         = level_q + LVL_W'(1);
      path_d[level_q] = w_decision;
      err_d           = err_q | ~w_fidx_ok;
      if (w_last) leaf_d = DEPTH'(w_child - NODE_W'(NODES));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      node_q  <= '0;
      level_q <= '0;
      path_q  <= '0;
      leaf_q  <= '0;
      err_q   <= 1'b0;
      for (int k = 0; k < N_FEAT; k++) feat_q[k] <= '0;
      for (int n = 0; n < NODES; n++) begin
        weight_q[n] <= '0;
        fidx_q[n]   <= '0;
      end
    end else begin
      node_q  <= node_d;
      level_q <= level_d;
      path_q  <= path_d;
      leaf_q  <= leaf_d;
      err_q   <= err_d;
      if (w_accept) begin
        for (int k = 0; k < N_FEAT; k++) feat_q[k] <= io_req_bits_features[k*DATA_W +: DATA_W];
      end
      if (w_cfg_wr) begin
        weight_q[io_cfg_addr] <= io_cfg_weight;
        fidx_q[io_cfg_addr]   <= io_cfg_fidx;
      end
    end
  end

  assign io_resp_bits_leaf = leaf_q;
  assign io_resp_bits_path = path_q;
  assign io_resp_bits_err  = err_q;

endmodule

`default_nettype wire

// File: tb/tb_tree_traversal_unit.sv
// tb_tree_traversal_unit: randomized and directed walks against a table-driven tree model.
// Revision 1.0
`default_nettype none

module tb_tree_traversal_unit;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // Main instance: N_FEAT = 4
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_addr = '0;
  logic [31:0] cfg_weight = '0;
  logic [1:0]  cfg_fidx = '0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [127:0] features = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [2:0]  leaf, path;
  logic        err, busy;

  // Second instance: N_FEAT = 3, so selector value 3 is out of range
  logic        c3_we = 1'b0;
  logic [2:0]  c3_addr = '0;
  logic [31:0] c3_weight = '0;
  logic [1:0]  c3_fidx = '0;
  logic        c3_valid = 1'b0;
  logic        c3_ready;
  logic [95:0] c3_features = '0;
  logic        c3_rvalid;
  logic        c3_rready = 1'b0;
  logic [2:0]  c3_leaf, c3_path;
  logic        c3_err, c3_busy;

  tree_traversal_unit #(.DATA_W(32), .DEPTH(3), .N_FEAT(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .io_cfg_we(cfg_we), .io_cfg_addr(cfg_addr), .io_cfg_weight(cfg_weight), .io_cfg_fidx(cfg_fidx),
    .io_req_valid(req_valid), .io_req_ready(req_ready), .io_req_bits_features(features),
    .io_resp_valid(resp_valid), .io_resp_ready(resp_ready),
    .io_resp_bits_leaf(leaf), .io_resp_bits_path(path), .io_resp_bits_err(err),
    .io_busy(busy)
  );

  tree_traversal_unit #(.DATA_W(32), .DEPTH(3), .N_FEAT(3)) dut3 (
    .clk(clk), .reset_n(reset_n),
    .io_cfg_we(c3_we), .io_cfg_addr(c3_addr), .io_cfg_weight(c3_weight), .io_cfg_fidx(c3_fidx),
    .io_req_valid(c3_valid), .io_req_ready(c3_ready), .io_req_bits_features(c3_features),
    .io_resp_valid(c3_rvalid), .io_resp_ready(c3_rready),
    .io_resp_bits_leaf(c3_leaf), .io_resp_bits_path(c3_path), .io_resp_bits_err(c3_err),
    .io_busy(c3_busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model state: index 0 = main instance, 1 = three-feature instance
  int m_w    [2][7];
  int m_f    [2][7];
  int m_feat [2][4];

  int last_leaf, last_path, last_err;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Walk the tree from the root using the spec's branching rules.
  function automatic void model(input int d, output int o_leaf, output int o_path, output int o_err);
    int node, nf, fi;
    bit dec;
    nf = (d != 0) ? 3 : 4;
    node = 0; o_path = 0; o_err = 0;
    for (int l = 0; l < 3; l++) begin
      fi = m_f[d][node];
      if (fi >= nf) begin
        dec = 1'b0;
        o_err = 1;
      end else begin
        dec = (m_feat[d][fi] <= m_w[d][node]);
      end
      if (dec) o_path |= (1 << l);
      node = dec ? 2 * node + 1 : 2 * node + 2;
    end
    o_leaf = node - 7;
  endfunction

  function automatic void model_clear();
    for (int d = 0; d < 2; d++)
      for (int n = 0; n < 7; n++) begin
        m_w[d][n] = 0;
        m_f[d][n] = 0;
      end
  endfunction

  task automatic cfg_write(input int addr, input int w, input int f);
    cfg_we = 1'b1; cfg_addr = 3'(addr); cfg_weight = w; cfg_fidx = 2'(f);
    if (addr < 7) begin
      m_w[0][addr] = w;
      m_f[0][addr] = f;
    end
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic set_feat(input int f0, input int f1, input int f2, input int f3);
    m_feat[0][0] = f0; m_feat[0][1] = f1; m_feat[0][2] = f2; m_feat[0][3] = f3;
  endtask

  task automatic do_walk(input int stall, input bit drop_wr, input bit same_wr,
                         input int wa, input int ww, input int wf);
    int el, ep, ee;
    for (int k = 0; k < 4; k++) features[k*32 +: 32] = m_feat[0][k];
    req_valid = 1'b1;
    if (same_wr) begin
      cfg_we = 1'b1; cfg_addr = 3'(wa); cfg_weight = ww; cfg_fidx = 2'(wf);
      if (wa < 7) begin
        m_w[0][wa] = ww;
        m_f[0][wa] = wf;
      end
    end
    check("req_ready_idle", req_ready, 1);
    model(0, el, ep, ee);
    tick();
    req_valid = 1'b0;
    cfg_we = 1'b0;
    check("busy_eval", busy, 1);
    tick();
    tick();
    check("valid_early", resp_valid, 0);
    tick();
    check("valid_lat", resp_valid, 1);
    check("leaf", leaf, el);
    check("path", path, ep);
    check("err", err, ee);
    last_leaf = int'(leaf); last_path = int'(path); last_err = int'(err);
    for (int i = 0; i < stall; i++) begin
      if (drop_wr && i == 0) begin
        cfg_we = 1'b1; cfg_addr = 3'd0; cfg_weight = 100; cfg_fidx = 2'd0;
      end
      tick();
      cfg_we = 1'b0;
      check("hold_valid", resp_valid, 1);
      check("hold_leaf", leaf, el);
      check("hold_path", path, ep);
      check("hold_req_ready", req_ready, 0);
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check("post_valid", resp_valid, 0);
    check("post_req_ready", req_ready, 1);
  endtask

  initial begin
    int el, ep, ee;
    model_clear();
    set_feat(0, 0, 0, 0);

    reset_n = 1'b0;
    tick(); tick();
    check("rst_valid", resp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_leaf", leaf, 0);
    check("rst_path", path, 0);
    check("rst_err", err, 0);
    reset_n = 1'b1;
    tick();
    check("rst_req_ready", req_ready, 1);

    // All-zero table and features: left at every level
    set_feat(0, 0, 0, 0);
    do_walk(0, 0, 0, 0, 0, 0);
    check("zero_leaf", last_leaf, 0);
    check("zero_path", last_path, 3'b111);
    check("zero_err", last_err, 0);

    set_feat(1, 0, 0, 0);
    do_walk(0, 0, 0, 0, 0, 0);
    check("pos_leaf", last_leaf, 7);
    check("pos_path", last_path, 3'b000);

    set_feat(-1, 0, 0, 0);
    do_walk(1, 0, 0, 0, 0, 0);
    check("neg_leaf", last_leaf, 0);

    // Equality goes left; one above goes right
    cfg_write(0, -5, 3);
    set_feat(0, 0, 0, -5);
    do_walk(0, 0, 0, 0, 0, 0);
    check("eq_left", last_path & 1, 1);
    set_feat(0, 0, 0, -4);
    do_walk(0, 0, 0, 0, 0, 0);
    check("gt_right", last_path & 1, 0);

    // Long stall with a write that must be dropped
    do_walk(10, 1, 0, 0, 0, 0);
    do_walk(0, 0, 0, 0, 0, 0);
    check("drop_wr_right", last_path & 1, 0);

    // Ignored write to the out-of-range address
    cfg_write(7, 55, 2);
    do_walk(0, 0, 0, 0, 0, 0);

    // Write accepted on the same edge as a request is used by that walk
    set_feat(0, 0, 0, -4);
    do_walk(0, 0, 1, 0, -4, 3);
    check("same_edge_left", last_path & 1, 1);

    // Randomized tables, features and stall lengths
    for (int n = 0; n < 7; n++)
      cfg_write(n, int'($urandom_range(20)) - 10, int'($urandom_range(3)));
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(2) == 0)
        cfg_write(int'($urandom_range(7)), int'($urandom_range(20)) - 10, int'($urandom_range(3)));
      for (int k = 0; k < 4; k++) begin
        case ($urandom_range(9))
          0:       m_feat[0][k] = 32'h7fffffff;
          1:       m_feat[0][k] = 32'h80000000;
          default: m_feat[0][k] = int'($urandom_range(20)) - 10;
        endcase
      end
      do_walk(int'($urandom_range(3)), 1'($urandom_range(1)), 1'($urandom_range(1)),
              int'($urandom_range(7)), int'($urandom_range(20)) - 10, int'($urandom_range(3)));
    end

    // Out-of-range selector on the three-feature instance
    m_feat[1][0] = 0; m_feat[1][1] = 0; m_feat[1][2] = 0; m_feat[1][3] = 0;
    check("c3_rst_ready", c3_ready, 1);
    c3_we = 1'b1; c3_addr = 3'd0; c3_weight = 1000; c3_fidx = 2'd3;
    m_w[1][0] = 1000; m_f[1][0] = 3;
    tick();
    c3_we = 1'b0;
    c3_features = '0;
    c3_valid = 1'b1;
    model(1, el, ep, ee);
    tick();
    c3_valid = 1'b0;
    tick(); tick(); tick();
    check("c3_valid", c3_rvalid, 1);
    check("c3_err", c3_err, 1);
    check("c3_path0_right", c3_path[0], 0);
    check("c3_leaf_const", c3_leaf, 4);
    check("c3_path_const", c3_path, 3'b110);
    check("c3_leaf_model", c3_leaf, el);
    c3_rready = 1'b1;
    tick();
    c3_rready = 1'b0;
    check("c3_post_valid", c3_rvalid, 0);

    // Reset during the second EVAL cycle
    set_feat(5, -3, 0, 0);
    for (int k = 0; k < 4; k++) features[k*32 +: 32] = m_feat[0][k];
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    reset_n = 1'b0;
    #1;
    check("async_valid", resp_valid, 0);
    check("async_busy", busy, 0);
    check("async_req_ready", req_ready, 1);
    model_clear();
    tick();
    reset_n = 1'b1;
    tick();
    check("post_rst_ready", req_ready, 1);
    check("post_rst_busy", busy, 0);
    check("post_rst_leaf", leaf, 0);
    do_walk(0, 0, 0, 0, 0, 0);
    check("post_rst_walk_leaf", last_leaf, 7);
    check("post_rst_walk_path", last_path, 3'b000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
